// File: rtl/proto_matrix_walker_if.sv
// Bundle of the walker's control, ROM-port and descriptor-stream signals.
// master: the walker side (drives ROM address and the descriptor stream).
// slave : the environment side (start/abort source, ROM, downstream consumer).
interface proto_matrix_walker_if #(
    parameter int Z = 54
);
    localparam int WIDTH = $clog2(Z);
    localparam int ADDRW = $clog2(4 * 24);

    logic             start;
    logic             abort;
    logic [ADDRW-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_row;
    logic [4:0]       out_col;
    logic [WIDTH-1:0] out_shift;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, rom_data, out_ready,
        output rom_addr, out_valid, out_row, out_col, out_shift, busy, done
    );

    modport slave (
        output start, abort, rom_data, out_ready,
        input  rom_addr, out_valid, out_row, out_col, out_shift, busy, done
    );
endinterface

// File: rtl/proto_matrix_walker.sv
// Prototype-matrix walker: scans the 4x24 prototype ROM row-major, drops null
// entries and streams (row, col, shift) descriptors over valid/ready.
// Optional feature macro: PROTO_WALK_CNT_EN adds nnz_cnt, the number of
// descriptors accepted in the current walk.
module proto_matrix_walker #(
    parameter int Z = 54
) (
    input  logic                   clk,
    input  logic                   rst,
    proto_matrix_walker_if.master  bus
`ifdef PROTO_WALK_CNT_EN
    ,
    output logic [6:0]             nnz_cnt
`endif
);
    localparam int ROWS  = 4;
    localparam int COLS  = 24;
    localparam int WIDTH = $clog2(Z);
    localparam int DEPTH = ROWS * COLS;
    localparam int ADDRW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] Z_V       = WIDTH'(Z);
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
    localparam logic [4:0]       LAST_COL  = 5'(COLS - 1);

    // Only the three supported lifting sizes have a matching ROM image.
    if (!(Z == 27 || Z == 54 || Z == 81)) begin : g_bad_z
        $fatal(1, "proto_matrix_walker: Z must be 27, 54 or 81");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [ADDRW-1:0] addr_q;
    logic [1:0]       row_q;
    logic [4:0]       col_q;
    logic             valid_q;
    logic [1:0]       orow_q;
    logic [4:0]       ocol_q;
    logic [WIDTH-1:0] oshift_q;
    logic             busy_q;
    logic             done_q;

    logic adv_d;
    logic live_d;
    logic last_d;
    logic accept_d;

    // Step/accept decode; out-of-range shifts (Z..NULL_V-1) count as null.
    always_comb begin
        adv_d    = !valid_q || bus.out_ready;
        live_d   = bus.rom_data < Z_V;
        last_d   = addr_q == LAST_ADDR;
        accept_d = valid_q && bus.out_ready;
    end

    // Walk sequencer with registered address, descriptor and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            row_q    <= 2'd0;
            col_q    <= 5'd0;
            valid_q  <= 1'b0;
            orow_q   <= 2'd0;
            ocol_q   <= 5'd0;
            oshift_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= ST_IDLE;
                addr_q  <= '0;
                row_q   <= 2'd0;
                col_q   <= 5'd0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_q <= ST_SCAN;
                            addr_q  <= '0;
                            row_q   <= 2'd0;
                            col_q   <= 5'd0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        // Nothing moves while a descriptor waits on out_ready.
                        if (adv_d) begin
                            if (live_d) begin
                                orow_q   <= row_q;
                                ocol_q   <= col_q;
                                oshift_q <= bus.rom_data;
                                valid_q  <= 1'b1;
                            end else begin
                                valid_q  <= 1'b0;
                            end
                            if (last_d) begin
                                // Park the counters at 0 so the ROM port stays in range.
                                state_q <= ST_DRAIN;
                                addr_q  <= '0;
                                row_q   <= 2'd0;
                                col_q   <= 5'd0;
                            end else begin
                                addr_q <= addr_q + ADDRW'(1);
                                if (col_q == LAST_COL) begin
                                    col_q <= 5'd0;
                                    row_q <= row_q + 2'd1;
                                end else begin
                                    col_q <= col_q + 5'd1;
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (adv_d) begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PROTO_WALK_CNT_EN
    logic [6:0] cnt_q;

    // Accepted-descriptor count: cleared on start/abort, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 7'd0;
        end else if (bus.abort) begin
            cnt_q <= 7'd0;
        end else if (state_q == ST_IDLE && bus.start) begin
            cnt_q <= 7'd0;
        end else if (accept_d) begin
            cnt_q <= cnt_q + 7'd1;
        end
    end

    assign nnz_cnt = cnt_q;
`endif

    assign bus.rom_addr  = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_row   = orow_q;
    assign bus.out_col   = ocol_q;
    assign bus.out_shift = oshift_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    proto_matrix_walker_chk #(
        .Z     (Z),
        .WIDTH (WIDTH)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .scan     (state_q == ST_SCAN),
        .rom_data (bus.rom_data)
    );
endmodule

// Flags ROM shifts that are neither a legal shift nor the null marker.
module proto_matrix_walker_chk #(
    parameter int Z     = 54,
    parameter int WIDTH = 6
) (
    input logic             clk,
    input logic             rst,
    input logic             scan,
    input logic [WIDTH-1:0] rom_data
);
    localparam logic [WIDTH-1:0] NULL_V = {WIDTH{1'b1}};

    a_rom_legal: assert property (@(posedge clk) disable iff (rst)
        scan |-> (rom_data < WIDTH'(Z) || rom_data == NULL_V))
        else $error("proto_matrix_walker: illegal ROM shift %0d", rom_data);
endmodule

// File: tb/tb_proto_matrix_walker.sv
// Directed bench for proto_matrix_walker (Z=54, NULL_V=63) with a ROM model.
module tb_proto_matrix_walker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    proto_matrix_walker_if #(.Z(54)) bus ();

`ifdef PROTO_WALK_CNT_EN
    logic [6:0] nnz_cnt;
    proto_matrix_walker #(.Z(54)) dut (.clk(clk), .rst(rst), .bus(bus), .nnz_cnt(nnz_cnt));
`else
    proto_matrix_walker #(.Z(54)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    logic [5:0] rom [0:95];
    assign bus.rom_data = rom[bus.rom_addr];

    // Walk record
    logic [1:0] d_row[$];
    logic [4:0] d_col[$];
    logic [5:0] d_shift[$];
    int         d_cyc[$];
    int         done_cyc;
    int         busy_low;
    int         stall_err;
    int         valid_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_null();
        for (int i = 0; i < 96; i++) rom[i] = 6'd63;
    endtask

    task automatic rom_t1();
        rom_null();
        rom[0]  = 6'd5;
        rom[25] = 6'd0;
        rom[95] = 6'd53;
    endtask

    task automatic rom_col();
        for (int i = 0; i < 96; i++) rom[i] = 6'(i % 24);
    endtask

    // Pulse start now, then run until done (cycle index = edges since start).
    task automatic walk(input bit rand_ready, input int restart_cyc, input int max_cyc);
        int cyc;
        bit stalled;
        logic [1:0] s_row;
        logic [4:0] s_col;
        logic [5:0] s_shift;
        d_row.delete(); d_col.delete(); d_shift.delete(); d_cyc.delete();
        done_cyc = -1; busy_low = 0; stall_err = 0; valid_seen = 0; stalled = 1'b0;
        s_row = 2'd0; s_col = 5'd0; s_shift = 6'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= max_cyc && done_cyc < 0) begin
            if (bus.done) begin
                done_cyc = cyc;
            end else begin
                if (!bus.busy) busy_low++;
                bus.start = (cyc == restart_cyc);
                if (stalled && !(bus.out_valid && bus.out_row == s_row &&
                                 bus.out_col == s_col && bus.out_shift == s_shift))
                    stall_err++;
                bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.out_valid) begin
                    valid_seen++;
                    if (bus.out_ready) begin
                        d_row.push_back(bus.out_row);
                        d_col.push_back(bus.out_col);
                        d_shift.push_back(bus.out_shift);
                        d_cyc.push_back(cyc);
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        s_row = bus.out_row; s_col = bus.out_col; s_shift = bus.out_shift;
                    end
                end else begin
                    stalled = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (bus.rom_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.rom_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if ({bus.out_row, bus.out_col, bus.out_shift} !== 13'd0) begin errors++;
            $display("FAIL reset_fields got=%0d/%0d/%0d exp=0/0/0", bus.out_row, bus.out_col, bus.out_shift); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", bus.busy, bus.done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_walk_basic();
        logic [1:0] er[3];
        logic [4:0] ec[3];
        logic [5:0] es[3];
        int         et[3];
        er = '{2'd0, 2'd1, 2'd3}; ec = '{5'd0, 5'd1, 5'd23};
        es = '{6'd5, 6'd0, 6'd53}; et = '{2, 27, 97};
        rom_t1();
        walk(1'b0, 0, 300);
        checks++; if (done_cyc !== 98) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=98", done_cyc); end
        checks++; if (d_row.size() !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", d_row.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= d_row.size()) begin
                errors++; $display("FAIL basic_desc%0d got=missing exp=(%0d,%0d,%0d)", i, er[i], ec[i], es[i]);
            end else if (d_row[i] !== er[i] || d_col[i] !== ec[i] || d_shift[i] !== es[i] || d_cyc[i] !== et[i]) begin
                errors++; $display("FAIL basic_desc%0d got=(%0d,%0d,%0d)@%0d exp=(%0d,%0d,%0d)@%0d", i,
                    d_row[i], d_col[i], d_shift[i], d_cyc[i], er[i], ec[i], es[i], et[i]);
            end
        end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL basic_busy got_low=%0d exp=0", busy_low); end
`ifdef PROTO_WALK_CNT_EN
        checks++; if (nnz_cnt !== 7'd3) begin errors++; $display("FAIL basic_nnz_cnt got=%0d exp=3", nnz_cnt); end
`endif
    endtask

    task automatic test_all_null();
        rom_null();
        walk(1'b0, 0, 300);
        checks++; if (done_cyc !== 98) begin errors++; $display("FAIL null_done_cycle got=%0d exp=98", done_cyc); end
        checks++; if (valid_seen !== 0) begin errors++; $display("FAIL null_valid got=%0d exp=0", valid_seen); end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL null_busy got_low=%0d exp=0", busy_low); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL null_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_stall();
        int bad;
        rom_col();
        walk(1'b1, 0, 3000);
        bad = 0;
        checks++; if (d_row.size() !== 96) begin errors++; $display("FAIL stall_count got=%0d exp=96", d_row.size()); end
        for (int i = 0; i < d_row.size() && i < 96; i++)
            if (d_row[i] !== 2'(i / 24) || d_col[i] !== 5'(i % 24) || d_shift[i] !== 6'(i % 24)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order got_bad=%0d exp=0", bad); end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_stable got=%0d exp=0", stall_err); end
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL stall_done got=timeout exp=done"); end
    endtask

    task automatic test_abort();
        int n;
        int hits;
        rom_col();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (n < 200 && !(bus.rom_addr == 7'd40 && bus.out_valid)) begin tick(); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL abort_reach got=timeout exp=addr40"); end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL abort_idle got valid=%b busy=%b exp=0/0", bus.out_valid, bus.busy); end
        checks++; if (bus.rom_addr !== 7'd0) begin errors++; $display("FAIL abort_addr got=%0d exp=0", bus.rom_addr); end
        hits = 0;
        for (int i = 0; i < 110; i++) begin if (bus.done || bus.busy) hits++; tick(); end
        checks++; if (hits !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", hits); end
`ifdef PROTO_WALK_CNT_EN
        checks++; if (nnz_cnt !== 7'd0) begin errors++; $display("FAIL abort_nnz_cnt got=%0d exp=0", nnz_cnt); end
`endif
        walk(1'b0, 0, 300);
        checks++; if (d_row.size() !== 96) begin errors++; $display("FAIL abort_rewalk_count got=%0d exp=96", d_row.size()); end
        checks++;
        if (d_row.size() == 0) begin errors++; $display("FAIL abort_rewalk_first got=none exp=(0,0,0)@2"); end
        else if (d_row[0] !== 2'd0 || d_col[0] !== 5'd0 || d_shift[0] !== 6'd0 || d_cyc[0] !== 2) begin errors++;
            $display("FAIL abort_rewalk_first got=(%0d,%0d,%0d)@%0d exp=(0,0,0)@2", d_row[0], d_col[0], d_shift[0], d_cyc[0]); end
    endtask

    task automatic test_async_reset();
        int hits;
        rom_col();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rom_addr !== 7'd0 || bus.out_shift !== 6'd0) begin
            errors++; $display("FAIL async_rst got valid=%b busy=%b addr=%0d shift=%0d exp=0/0/0/0",
                bus.out_valid, bus.busy, bus.rom_addr, bus.out_shift); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        rom_t1();
        walk(1'b0, 50, 300);
        checks++; if (done_cyc !== 98 || d_row.size() !== 3) begin errors++;
            $display("FAIL start_ignored got done=%0d n=%0d exp=98/3", done_cyc, d_row.size()); end
        hits = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus.busy) hits++; end
        checks++; if (hits !== 0) begin errors++; $display("FAIL start_ignored_busy got=%0d exp=0", hits); end
    endtask

    task automatic test_back_to_back();
        rom_t1();
        walk(1'b0, 0, 300);
        walk(1'b0, 0, 300);
        checks++; if (done_cyc !== 98 || d_row.size() !== 3) begin errors++;
            $display("FAIL b2b_second got done=%0d n=%0d exp=98/3", done_cyc, d_row.size()); end
`ifdef PROTO_WALK_CNT_EN
        checks++; if (nnz_cnt !== 7'd3) begin errors++; $display("FAIL b2b_nnz_cnt got=%0d exp=3", nnz_cnt); end
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        rom_null();
        test_reset();
        test_walk_basic();
        test_all_null();
        test_stall();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
